// File: rtl/speed_meter_pkg.sv
// Shared bike-computer definitions: measurement FSM states, wheel constant
// and the speed width agreed between speed_meter and the max-speed tracker.
package speed_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNT,
        DIVIDE
    } state_t;

    localparam int unsigned WHEEL_CIRC_MM = 2120;
    // km/h = circumference_mm * 3.6 / period_ms
    localparam int unsigned K_DEFAULT     = WHEEL_CIRC_MM * 36 / 10;
    localparam int unsigned SPEED_W       = 7;

endpackage

// File: rtl/speed_meter_if.sv
// Speed-sample interface between speed_meter (producer) and its consumers.
interface speed_meter_if
    import speed_meter_pkg::*;
#(
    parameter int unsigned WIDTH = SPEED_W
);

    logic [WIDTH-1:0] speed;
    logic             speed_valid;
    logic             moving;

    modport master (output speed, speed_valid, moving);
    modport slave  (input  speed, speed_valid, moving);

endinterface

// File: rtl/speed_meter_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock after a start pulse.
module serial_divider
    import speed_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [CNT_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] quotient
);

    localparam int unsigned STEP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  quo;
    logic [CNT_W-1:0]  dsr;
    logic [STEP_W-1:0] step;
    logic              run;

    logic [CNT_W:0]    trial;
    logic              fits;
    logic [CNT_W-1:0]  rem_nx;
    logic [CNT_W-1:0]  quo_nx;

    always_comb begin
        trial  = {rem, quo[CNT_W-1]};
        fits   = (trial >= {1'b0, dsr});
        rem_nx = fits ? CNT_W'(trial - {1'b0, dsr}) : trial[CNT_W-1:0];
        quo_nx = {quo[CNT_W-2:0], fits};
    end

    // Result is taken from the last step combinationally, saving a cycle.
    assign busy     = run;
    assign done     = run && (step == STEP_W'(CNT_W - 1));
    assign quotient = quo_nx;

    always_ff @(posedge clk) begin
        if (!r) begin
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            step <= '0;
            run  <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= dividend;
            dsr  <= divisor;
            step <= '0;
            run  <= 1'b1;
        end else if (run) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            step <= step + STEP_W'(1);
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/speed_meter.sv
// Wheel-speed front end: reed synchroniser/debounce, period counter and
// km/h conversion through a serial divider, with timeout to zero speed.
module speed_meter
    import speed_meter_pkg::*;
#(
    parameter int unsigned WIDTH    = SPEED_W,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned K        = K_DEFAULT,
    parameter int unsigned DEBOUNCE = 20,
    parameter int unsigned TIMEOUT  = 3000
) (
    input  logic          clk,
    input  logic          r,
    input  logic          tick,
    input  logic          reed,
    speed_meter_if.master sp
);

    localparam logic [CNT_W-1:0] K_C    = CNT_W'(K);
    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

    logic             s1, s2, s2_d, rise_det;
    state_t           state, state_nx;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] divisor;
    logic             start, discard;
    logic [WIDTH-1:0] speed_q;
    logic             valid_q;

    logic             busy, done;
    logic [CNT_W-1:0] quotient;
    logic [WIDTH-1:0] sat_speed;
    logic             qualified, accept, expire;

    serial_divider #(.CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .r        (r),
        .start    (start),
        .dividend (K_C),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (!r) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s2_d     <= 1'b0;
            rise_det <= 1'b0;
        end else begin
            s1       <= reed;
            s2       <= s1;
            s2_d     <= s2;
            rise_det <= s2 & ~s2_d;
        end
    end

    assign qualified = rise_det && (pcnt >= DEB_C);
    assign sat_speed = (|quotient[CNT_W-1:WIDTH]) ? '1 : quotient[WIDTH-1:0];

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (rise_det) begin
                    accept   = 1'b1;
                    state_nx = ARMED;
                end
            end
            ARMED, COUNT: begin
                if (qualified) begin
                    accept   = 1'b1;
                    state_nx = DIVIDE;
                end else if ((pcnt >= TMO_C) || (tick && (pcnt == TMO_M1))) begin
                    expire   = 1'b1;
                    state_nx = IDLE;
                end
            end
            DIVIDE: begin
                accept = qualified;
                // Leaving on an idle divider guards against a lost done.
                if (done || !(busy || start))
                    state_nx = COUNT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            state   <= IDLE;
            pcnt    <= '0;
            divisor <= '0;
            start   <= 1'b0;
            discard <= 1'b0;
            speed_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start   <= 1'b0;
            valid_q <= 1'b0;
            if (state == IDLE || accept || expire)
                pcnt <= '0;
            else if (tick)
                pcnt <= pcnt + CNT_W'(1);
            case (state)
                ARMED, COUNT: begin
                    if (accept) begin
                        divisor <= pcnt;
                        start   <= 1'b1;
                        discard <= 1'b0;
                    end else if (expire) begin
                        speed_q <= '0;
                        valid_q <= 1'b1;
                    end
                end
                DIVIDE: begin
                    // A boundary inside the division restarts the period
                    // measurement and makes the running result stale.
                    if (accept)
                        discard <= 1'b1;
                    if (done && !discard && !accept) begin
                        speed_q <= sat_speed;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sp.speed       = speed_q;
    assign sp.speed_valid = valid_q;
    assign sp.moving      = (state != IDLE);

endmodule

// File: tb/tb_speed_meter.sv
// Scoreboard bench for speed_meter: reed rises are scheduled by cycle, an
// event-level wheel model predicts each speed sample, a monitor checks them.
module tb_speed_meter;

    localparam int unsigned W        = 7;
    localparam int unsigned CW       = 16;
    localparam int unsigned KV       = 7632;
    localparam int unsigned DEB      = 20;
    localparam int unsigned TMO      = 3000;
    localparam int unsigned SYNC_LAT = 3;
    localparam int unsigned DIV_LAT  = CW + 2;
    localparam int unsigned SMAX     = (1 << W) - 1;

    typedef struct {
        int unsigned at;
        int unsigned spd;
    } exp_t;

    logic        clk  = 1'b0;
    logic        r    = 1'b0;
    logic        tick = 1'b1;
    logic        reed = 1'b0;
    int unsigned cyc  = 0;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    bit          active     = 1'b0;
    int unsigned last_acc   = 0;
    bit          div_seen   = 1'b0;
    int unsigned div_start  = 0;
    bit          div_live   = 1'b0;
    int unsigned last_rise  = 0;

    int unsigned steady [9] = '{100, 100, 100, 50, 50, 50, 60, 60, 60};

    speed_meter_if #(.WIDTH(W)) sif ();

    speed_meter #(
        .WIDTH    (W),
        .CNT_W    (CW),
        .K        (KV),
        .DEBOUNCE (DEB),
        .TIMEOUT  (TMO)
    ) dut (
        .clk  (clk),
        .r    (r),
        .tick (tick),
        .reed (reed),
        .sp   (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned kmh(input int unsigned p);
        int unsigned q;
        q = KV / p;
        return (q > SMAX) ? SMAX : q;
    endfunction

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Wheel stops: no accepted edge for TMO ticks gives a zero sample one cycle later.
    task automatic model_expire(input int unsigned horizon);
        if (active && (last_acc + TMO <= horizon)) begin
            sb.push_back('{at: last_acc + TMO + 1, spd: 0});
            active = 1'b0;
        end
    endtask

    // Edge seen at cycle d; period = ticks counted since the clear after the last accepted edge.
    task automatic model_edge(input int unsigned d);
        int unsigned p;
        model_expire(d - 1);
        if (!active) begin
            active   = 1'b1;
            last_acc = d;
            return;
        end
        p = d - last_acc - 1;
        if (p < DEB)
            return;
        if (div_seen && (d <= div_start + CW + 1)) begin
            if (div_live) begin
                void'(sb.pop_back());
                div_live = 1'b0;
            end
        end else begin
            sb.push_back('{at: d + DIV_LAT, spd: kmh(p)});
            div_seen  = 1'b1;
            div_start = d;
            div_live  = 1'b1;
        end
        last_acc = d;
    endtask

    task automatic model_reset(input int unsigned k);
        while (sb.size() > 0 && sb[sb.size()-1].at > k)
            void'(sb.pop_back());
        active   = 1'b0;
        div_seen = 1'b0;
        div_live = 1'b0;
    endtask

    task automatic wait_until(input int unsigned t);
        model_expire(t + SYNC_LAT - 1);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise_at(input int unsigned t);
        if (t <= cyc)
            check("schedule", cyc, t - 1);
        wait_until(t);
        reed = 1'b1;
        model_edge(t + SYNC_LAT);
        last_rise = t;
        wait_until(t + 2);
        reed = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sif.speed_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: cycle %0d speed %0d, no sample expected", cyc, sif.speed);
            end else begin
                mon_e = sb.pop_front();
                if (int'(sif.speed) != mon_e.spd || cyc != mon_e.at) begin
                    n_bad++;
                    $display("FAIL speed_sample: cycle %0d speed %0d, expected cycle %0d speed %0d",
                             cyc, sif.speed, mon_e.at, mon_e.spd);
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_valid: no strobe by cycle %0d, expected cycle %0d speed %0d",
                     cyc, mon_e.at, mon_e.spd);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_speed", sif.speed, 0);
        check("rst_valid", sif.speed_valid, 0);
        check("rst_moving", sif.moving, 0);
        r = 1'b1;

        // First edge arms, second edge 1000 ticks later gives 7 km/h.
        base = cyc + 10;
        rise_at(base);
        wait_until(base + 12);
        check("armed_moving", sif.moving, 1);
        check("armed_speed", sif.speed, 0);
        rise_at(base + 1001);
        wait_until(cyc + 30);
        check("speed_1000", sif.speed, 7);

        // Steady riding at 100, 50 (saturated) and 60 (exactly 127) ticks.
        for (int i = 0; i < 9; i++)
            rise_at(last_rise + steady[i] + 1);
        wait_until(cyc + 30);
        check("speed_60_hold", sif.speed, 127);

        // Reed bounce after a valid edge is ignored.
        rise_at(last_rise + 101);
        base = last_rise;
        for (int i = 1; i <= 3; i++)
            rise_at(base + 5 * i);
        rise_at(base + 101);
        wait_until(cyc + 30);
        check("bounce_speed", sif.speed, 76);

        // No pulses: zero speed at timeout, then re-arm without a strobe.
        wait_until(last_rise + 3100);
        check("timeout_speed", sif.speed, 0);
        check("timeout_moving", sif.moving, 0);
        rise_at(cyc + 5);
        wait_until(cyc + 10);
        check("rearm_moving", sif.moving, 1);

        // Edge during the division, then a short 24-tick period.
        rise_at(last_rise + 101);
        base = last_rise;
        rise_at(base + 12);
        rise_at(base + 101);
        rise_at(last_rise + 25);
        rise_at(last_rise + 101);
        wait_until(cyc + 30);
        check("after_short_speed", sif.speed, 76);

        // Random periods, some inside the debounce window.
        for (int i = 0; i < 16; i++)
            rise_at(last_rise + $urandom_range(400, 8) + 1);
        wait_until(cyc + 30);

        // Reset five cycles into a division.
        rise_at(last_rise + 101);
        d = last_rise + SYNC_LAT;
        wait_until(d + 5);
        r = 1'b0;
        model_reset(cyc);
        wait_until(cyc + 3);
        r = 1'b1;
        check("midreset_speed", sif.speed, 0);
        check("midreset_moving", sif.moving, 0);
        wait_until(cyc + 40);
        check("post_reset_speed", sif.speed, 0);
        rise_at(cyc + 5);
        rise_at(last_rise + 101);
        wait_until(cyc + 40);
        check("recover_speed", sif.speed, 76);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
